// File: rtl/weight_cmd_pkg.sv
// Shared constants, state encodings and the baud divisor for the weight command receiver.
// Build macro CMD_RX_TIMEOUT_EN enables the inter-byte timeout in weight_cmd_rx.
package weight_cmd_pkg;

  localparam logic [7:0] HDR_BYTE    = 8'hA5;
  localparam logic [7:0] CMD_SET_MIN = 8'h01;
  localparam logic [7:0] CMD_SET_MAX = 8'h02;
  localparam logic [7:0] CMD_START   = 8'h03;
  localparam logic [7:0] CMD_ABORT   = 8'h04;

  localparam int unsigned DIV_W = 16;

  typedef enum logic [2:0] {
    P_HDR,
    P_CMD,
    P_DHI,
    P_DLO,
    P_SUM
  } parse_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Clocks per 16x oversampling tick, minus one; baud_set 4..7 all select 115200.
  function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_freq,
                                                input logic [2:0] sel);
    int unsigned baud;
    baud = 115200;
    case (sel)
      3'd0:    baud = 9600;
      3'd1:    baud = 19200;
      3'd2:    baud = 38400;
      3'd3:    baud = 57600;
      default: baud = 115200;
    endcase
    return DIV_W'(clk_freq / (16 * baud) - 1);
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 2-flop synchroniser, 16x oversampling, 2-of-3 majority per bit.
// Baud selection is captured at start-bit detection and held for the whole byte.
module uart_byte_rx
  import weight_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  input  logic [2:0] i_baud_set,
  output logic [7:0] o_data,
  output logic       o_done,
  output logic       o_frame_err
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_rx_prev;
  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_baud_cnt;
  logic [3:0]       r_tick_cnt;
  logic [2:0]       r_bit_idx;
  logic             r_s7;
  logic             r_s8;
  logic [7:0]       r_shift;

  logic w_fall;
  logic w_tick;
  logic w_decide;
  logic w_bit_end;
  logic w_vote;

  assign w_fall    = r_rx_prev & ~r_sync2;
  assign w_tick    = (r_state != RX_IDLE) && (r_baud_cnt == r_div);
  // Tick counts 6/7/8 are samples 7/8/9; the third sample is taken live at the decision.
  assign w_decide  = w_tick && (r_tick_cnt == 4'd8);
  assign w_bit_end = w_tick && (r_tick_cnt == 4'd15);
  assign w_vote    = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= i_rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= RX_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_state_nxt = RX_START;
      RX_START: begin
        if (w_decide && w_vote) w_state_nxt = RX_IDLE;
        else if (w_bit_end)     w_state_nxt = RX_DATA;
      end
      RX_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_state_nxt = RX_STOP;
      RX_STOP:  if (w_decide) w_state_nxt = RX_IDLE;
      default:  w_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div       <= '0;
      r_baud_cnt  <= '0;
      r_tick_cnt  <= '0;
      r_bit_idx   <= '0;
      r_s7        <= 1'b1;
      r_s8        <= 1'b1;
      r_shift     <= '0;
      o_data      <= '0;
      o_done      <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_done      <= 1'b0;
      o_frame_err <= 1'b0;
      if (r_state == RX_IDLE) begin
        r_baud_cnt <= '0;
        r_tick_cnt <= '0;
        r_bit_idx  <= '0;
        if (w_fall) r_div <= baud_div(CLK_FREQ, i_baud_set);
      end else begin
        r_baud_cnt <= w_tick ? '0 : r_baud_cnt + DIV_W'(1);
        if (w_tick) begin
          r_tick_cnt <= r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd6) r_s7 <= r_sync2;
          if (r_tick_cnt == 4'd7) r_s8 <= r_sync2;
        end
        if (w_decide) begin
          case (r_state)
            RX_DATA: r_shift <= {w_vote, r_shift[7:1]};
            RX_STOP: begin
              if (w_vote) begin
                o_done <= 1'b1;
                o_data <= r_shift;
              end else begin
                o_frame_err <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        if (w_bit_end && (r_state == RX_DATA)) r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

endmodule

// File: rtl/weight_cmd_rx.sv
// Host command receiver: parses A5/CMD/DHI/DLO/SUM frames into weight window updates and strobes.
// Build macro CMD_RX_TIMEOUT_EN adds an inter-byte timeout that abandons partial frames.
module weight_cmd_rx
  import weight_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned TIMEOUT_CYC = 500_000,
  parameter logic [11:0] MIN_RST     = 12'd768,
  parameter logic [11:0] MAX_RST     = 12'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [2:0]  baud_set,
  output logic [7:0]  rx_data,
  output logic        rx_done,
  output logic [11:0] weight_min,
  output logic [11:0] weight_max,
  output logic        cmd_start,
  output logic        cmd_abort,
  output logic        frame_err
);

  logic         w_byte_err;
  parse_state_t r_state;
  parse_state_t w_state_nxt;
  logic [7:0]   r_cmd;
  logic [7:0]   r_dhi;
  logic [7:0]   r_dlo;
  logic [11:0]  w_data;
  logic         w_sum_ok;
  logic         w_sum_frame;
  logic         w_accept;
  logic         w_timeout;

  uart_byte_rx #(
    .CLK_FREQ(CLK_FREQ)
  ) u_byte_rx (
    .clk        (clk),
    .rst        (rst),
    .i_rx       (rx),
    .i_baud_set (baud_set),
    .o_data     (rx_data),
    .o_done     (rx_done),
    .o_frame_err(w_byte_err)
  );

  assign w_data      = {r_dhi[3:0], r_dlo};
  assign w_sum_ok    = (rx_data == 8'(r_cmd + r_dhi + r_dlo));
  assign w_sum_frame = rx_done && (r_state == P_SUM);

`ifdef CMD_RX_TIMEOUT_EN
  logic [31:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (rst || rx_done || (r_state == P_HDR) || w_timeout) r_to_cnt <= '0;
    else                                                   r_to_cnt <= r_to_cnt + 32'd1;
  end

  assign w_timeout = (r_state != P_HDR) && !rx_done && (r_to_cnt == TIMEOUT_CYC);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= P_HDR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    if (w_byte_err || w_timeout) begin
      w_state_nxt = P_HDR;
    end else if (rx_done) begin
      case (r_state)
        P_HDR: if (rx_data == HDR_BYTE) w_state_nxt = P_CMD;
        P_CMD: w_state_nxt = P_DHI;
        P_DHI: w_state_nxt = P_DLO;
        P_DLO: w_state_nxt = P_SUM;
        P_SUM: begin
          w_state_nxt = P_HDR;
          // Window checks compare against the current opposite bound, so the window never collapses.
          if (w_sum_ok && (r_dhi[7:4] == 4'd0)) begin
            case (r_cmd)
              CMD_SET_MIN: w_accept = (w_data < weight_max);
              CMD_SET_MAX: w_accept = (w_data > weight_min);
              CMD_START:   w_accept = 1'b1;
              CMD_ABORT:   w_accept = 1'b1;
              default:     w_accept = 1'b0;
            endcase
          end
        end
        default: w_state_nxt = P_HDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd      <= '0;
      r_dhi      <= '0;
      r_dlo      <= '0;
      weight_min <= MIN_RST;
      weight_max <= MAX_RST;
      cmd_start  <= 1'b0;
      cmd_abort  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cmd_start <= 1'b0;
      cmd_abort <= 1'b0;
      frame_err <= w_byte_err || w_timeout || (w_sum_frame && !w_accept);
      if (rx_done) begin
        case (r_state)
          P_CMD:   r_cmd <= rx_data;
          P_DHI:   r_dhi <= rx_data;
          P_DLO:   r_dlo <= rx_data;
          default: ;
        endcase
      end
      if (w_sum_frame && w_accept) begin
        case (r_cmd)
          CMD_SET_MIN: weight_min <= w_data;
          CMD_SET_MAX: weight_max <= w_data;
          CMD_START:   cmd_start  <= 1'b1;
          CMD_ABORT:   cmd_abort  <= 1'b1;
          default:     ;
        endcase
      end
    end
  end

endmodule

// File: doc/weight_cmd_rx.md
# weight_cmd_rx

Host-to-FPGA command receiver for the weight-training system: the receive-side counterpart to the existing `uart_tx` weight report stream. It deserialises 8N1 UART bytes from the host and parses fixed 5-byte command frames. From these it updates the programmable weight window (`weight_min`/`weight_max`) and issues start/abort strobes to the system state machine. It sits beside `uart_tx` under the system top and shares its `baud_set` encoding.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `TIMEOUT_CYC`, 500_000: inter-byte timeout in clocks (10 ms at 50 MHz). Used only with `CMD_RX_TIMEOUT_EN`.
- `MIN_RST`, 12'd768: reset value of `weight_min`.
- `MAX_RST`, 12'd1024: reset value of `weight_max`.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: reset, synchronous, active-high.
- `rx` in 1: UART line, asynchronous. Idle level is high.
- `baud_set` in 3: 0=9600, 1=19200, 2=38400, 3=57600, 4..7=115200.
- `rx_data` out 8: last received byte. Reset value 0.
- `rx_done` out 1: one-clock pulse when a byte is accepted. Reset value 0.
- `weight_min` out 12: lower weight threshold. Reset value `MIN_RST`.
- `weight_max` out 12: upper weight threshold. Reset value `MAX_RST`.
- `cmd_start` out 1: one-clock start strobe. Reset value 0.
- `cmd_abort` out 1: one-clock abort strobe. Reset value 0.
- `frame_err` out 1: one-clock error strobe. Reset value 0.

## Operation
Byte receiver:
- `rx` passes through a 2-flop synchroniser. A falling edge in IDLE starts reception.
- Oversampling is 16x. The tick divisor is floor(CLK_FREQ/(16*baud))-1, i.e. 324/161/80/53/26 at 50 MHz.
- States are IDLE→START→DATA(8 bits, LSB first)→STOP→IDLE.
- Each bit is decided by a 2-of-3 majority of samples 7, 8 and 9.
- START majority high → false start: return to IDLE with no output.
- STOP majority low → framing error: byte discarded, `frame_err` pulses, parser returns to HDR.
- `baud_set` is sampled at start-bit detection and held for the whole byte.

Frame parser (advances on each `rx_done`):
- States: HDR→CMD→DHI→DLO→SUM→HDR.
- HDR accepts only 0xA5. Any other byte is silently dropped, which gives resynchronisation.
- Payload: DATA[11:0] = {DHI[3:0], DLO}. DHI[7:4] must be 0.
- SUM must equal (CMD+DHI+DLO) mod 256.
- Commands:
  - 0x01: set `weight_min`.
  - 0x02: set `weight_max`.
  - 0x03: `cmd_start`; data is ignored but must be checksummed.
  - 0x04: `cmd_abort`.
- Rejection: any of the following pulses `frame_err` and leaves all registers unchanged:
  - checksum mismatch;
  - DHI[7:4]≠0;
  - unknown CMD;
  - new min ≥ current max;
  - new max ≤ current min.
- The parser always returns to HDR after SUM, whether the frame was accepted or rejected.

## Timing
- `rx_done` and `rx_data` update one clock after the STOP-bit majority decision.
- Command outputs (register update or strobe) appear one clock after the SUM byte's `rx_done`.
- Total latency from STOP sample 9 to the command output is 2 clocks.
- `frame_err`, `cmd_start` and `cmd_abort` are mutually exclusive in any cycle.
- `rst` mid-byte or mid-frame: receiver returns to IDLE, parser to HDR, all outputs return to their reset values on the next edge.
- A `rx` falling edge during STOP (back-to-back bytes) is detected once STOP completes. No byte is lost when the line is idle for ≥1 sample.

## Configuration
- `CMD_RX_TIMEOUT_EN` defined:
  - A counter clears on each `rx_done` and runs while the parser is not in HDR.
  - When it reaches `TIMEOUT_CYC`, the parser returns to HDR and `frame_err` pulses once.
- `CMD_RX_TIMEOUT_EN` undefined: no counter; a partial frame waits indefinitely.

## Structure
- Package `weight_cmd_pkg`: header 0xA5, command codes 0x01–0x04, parser state enum, baud divisor function.
- Sub-module `uart_byte_rx`: synchroniser, oversampling, bit FSM. Outputs `rx_data`, `rx_done`, and a framing-error strobe.
- Parser, validation and the weight registers live in `weight_cmd_rx`.

## Test plan
- **Reset and idle:** assert `rst`, then idle line → `weight_min`=768, `weight_max`=1024; all strobes 0; `rx_done` never pulses.
- **Valid set-min:** `baud_set`=4; send A5 01 03 20 24 → five `rx_done` pulses; `weight_min`=800 exactly 2 clocks after the last stop sample; no `frame_err`.
- **Bad checksum:** send A5 01 03 20 25 → `frame_err` one pulse; `weight_min` unchanged. Then send 00 A5 03 00 00 03 → `cmd_start` one pulse, proving resync.
- **Window violation:** send A5 01 04 00 05 (min=1024, equal to max) → `frame_err`; `weight_min` stays 768.
- **Line errors:** a 3-tick low glitch → no byte. A byte whose stop bit is forced low → `frame_err`; the parser is back in HDR.
- **Timeout:** with `CMD_RX_TIMEOUT_EN` defined, send A5 01 then stay idle for `TIMEOUT_CYC`+10 → one `frame_err`; a following full frame is accepted. Without the macro, no `frame_err`.
